vga_stream_gen: RTL and testbench

- Parametrised successor of the fixed 800x480 VGA timing block.
- Generates HS/VS/BLANK timing with parameter-defined porches and sync polarities, and fixes the counter wrap so that one line is exactly HTOTAL clocks.
- Drives RGB from one of four runtime-selectable sources: grid pattern, colour bars, solid colour, or a ready/valid pixel stream from the framebuffer FIFO.
- Sits between the framebuffer read path and the video_if master port.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/video_if.sv | 11 +
 rtl/vga_timing_core.sv | 58 +++++
 rtl/vga_stream_gen.sv | 128 ++++++++++++
 tb/tb_vga_stream_gen.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the parametrised VGA stream generator.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    GRID   = 2'd0,
    BARS   = 2'd1,
    SOLID  = 2'd2,
    STREAM = 2'd3
  } mode_e;

  // Element 0 is the leftmost bar (white), element 7 the rightmost (black).
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic int vga_total(input int front, input int pulse, input int back, input int disp);
    return front + pulse + back + disp;
  endfunction

endpackage

// File: rtl/video_if.sv
// Video output bundle from the timing generator to the display side.
interface video_if;
  logic        CLK;
  logic [23:0] RGB;
  logic        HS;
  logic        VS;
  logic        BLANK;

  modport master (output CLK, RGB, HS, VS, BLANK);
  modport slave  (input  CLK, RGB, HS, VS, BLANK);
endinterface

// File: rtl/vga_timing_core.sv
// Line/frame counters with sync, active-area and pixel coordinate decode.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter  int HDISP  = 800,
  parameter  int VDISP  = 480,
  parameter  int HFP    = 40,
  parameter  int HPULSE = 48,
  parameter  int HBP    = 40,
  parameter  int VFP    = 13,
  parameter  int VPULSE = 3,
  parameter  int VBP    = 29,
  localparam int HBLANK = HFP + HPULSE + HBP,
  localparam int VBLANK = VFP + VPULSE + VBP,
  localparam int HTOTAL = vga_total(HFP, HPULSE, HBP, HDISP),
  localparam int VTOTAL = vga_total(VFP, VPULSE, VBP, VDISP),
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  output logic          hs_act,
  output logic          vs_act,
  output logic          active,
  output logic          frame_start,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y
);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(HTOTAL - 1));
  assign v_last = (v_cnt == VW'(VTOTAL - 1));

  // h_cnt wraps at HTOTAL-1 so a line is exactly HTOTAL clocks.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign hs_act      = (h_cnt >= HW'(HFP)) && (h_cnt < HW'(HFP + HPULSE));
  assign vs_act      = (v_cnt >= VW'(VFP)) && (v_cnt < VW'(VFP + VPULSE));
  assign active      = (h_cnt >= HW'(HBLANK)) && (v_cnt >= VW'(VBLANK));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign x           = h_cnt - HW'(HBLANK);
  assign y           = v_cnt - VW'(VBLANK);

endmodule

// File: rtl/vga_stream_gen.sv
// VGA timing plus runtime-selectable pixel source (grid, bars, solid, FIFO stream).
module vga_stream_gen
  import vga_pkg::*;
#(
  parameter  int          HDISP     = 800,
  parameter  int          VDISP     = 480,
  parameter  int          HFP       = 40,
  parameter  int          HPULSE    = 48,
  parameter  int          HBP       = 40,
  parameter  int          VFP       = 13,
  parameter  int          VPULSE    = 3,
  parameter  int          VBP       = 29,
  parameter  logic        HS_POL    = 1'b0,
  parameter  logic        VS_POL    = 1'b0,
  parameter  int          GRID_STEP = 16,
  parameter  logic [23:0] UFLOW_RGB = 24'hFF00FF,
  localparam int          HW        = $clog2(vga_total(HFP, HPULSE, HBP, HDISP)),
  localparam int          VW        = $clog2(vga_total(VFP, VPULSE, VBP, VDISP))
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_rdy,
  output logic        pix_sof,
  output logic        uflow,
  input  logic        uflow_clr,
  video_if.master     video_ifm
);

  localparam int            BAR_W  = HDISP / 8;
  localparam logic [HW-1:0] HMASK  = HW'(GRID_STEP - 1);
  localparam logic [VW-1:0] VMASK  = VW'(GRID_STEP - 1);

  logic          hs_act, vs_act, active, frame_start;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  mode_e         mode_q;
  rgb_t          solid_q;
  logic [2:0]    bar_idx;
  logic          grid_on;
  logic          underflow;
  logic [23:0]   rgb_next;
  logic [23:0]   rgb_q;
  logic          hs_q, vs_q, blank_q;

  vga_timing_core #(
    .HDISP(HDISP), .VDISP(VDISP),
    .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) u_timing (
    .pixel_clk   (pixel_clk),
    .pixel_rst   (pixel_rst),
    .hs_act      (hs_act),
    .vs_act      (vs_act),
    .active      (active),
    .frame_start (frame_start),
    .x           (x),
    .y           (y)
  );

  // Source selection only changes on frame boundaries so a frame is never mixed.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      mode_q  <= GRID;
      solid_q <= '0;
    end else if (frame_start) begin
      mode_q  <= mode_e'(mode);
      solid_q <= solid_rgb;
    end
  end

  assign pix_rdy   = !pixel_rst && active && (mode_q == STREAM);
  assign pix_sof   = pix_rdy && (x == '0) && (y == '0);
  assign underflow = pix_rdy && !pix_valid;
  assign grid_on   = ((x & HMASK) == '0) || ((y & VMASK) == '0);

  // Last bar starts at 7*BAR_W and absorbs any remainder of HDISP/8.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (x >= HW'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  always_comb begin
    rgb_next = '0;
    if (active) begin
      case (mode_q)
        GRID:    rgb_next = grid_on ? 24'hFFFFFF : 24'h000000;
        BARS:    rgb_next = BAR_RGB[bar_idx];
        SOLID:   rgb_next = solid_q;
        STREAM:  rgb_next = pix_valid ? pix_data : UFLOW_RGB;
        default: rgb_next = '0;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs_q    <= hs_act ? HS_POL : ~HS_POL;
      vs_q    <= vs_act ? VS_POL : ~VS_POL;
      blank_q <= active;
      rgb_q   <= rgb_next;
    end
  end

  // A new underflow takes priority over a clear arriving in the same cycle.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst)      uflow <= 1'b0;
    else if (underflow) uflow <= 1'b1;
    else if (uflow_clr) uflow <= 1'b0;
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.RGB   = rgb_q;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;

endmodule

// File: tb/tb_vga_stream_gen.sv
// Self-checking bench for vga_stream_gen: cycle-count model plus directed literal checks.
module tb_vga_stream_gen;

  localparam int HDISP = 8, VDISP = 4, HFP = 2, HPULSE = 2, HBP = 2;
  localparam int VFP = 1, VPULSE = 1, VBP = 1, GRID_STEP = 4;
  localparam int HB = HFP + HPULSE + HBP;
  localparam int VB = VFP + VPULSE + VBP;
  localparam int HT = HB + HDISP;
  localparam int VT = VB + VDISP;
  localparam int FRAME = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_rdy;
  logic        pix_sof;
  logic        uflow;
  logic        uflow_clr;

  video_if vif ();

  vga_stream_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0),
    .GRID_STEP(GRID_STEP), .UFLOW_RGB(24'hFF00FF)
  ) dut (
    .pixel_clk (pixel_clk),
    .pixel_rst (pixel_rst),
    .mode      (mode),
    .solid_rgb (solid_rgb),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_rdy   (pix_rdy),
    .pix_sof   (pix_sof),
    .uflow     (uflow),
    .uflow_clr (uflow_clr),
    .video_ifm (vif)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: position is the cycle count since reset modulo the frame.
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  bit          model_on = 1'b0;
  int          mt = 0;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic        m_uflow, e_hs, e_vs, e_blank;
  logic [23:0] e_rgb;

  function automatic logic [23:0] modelPixel(input int h, input int v, input logic [1:0] md,
                                              input logic [23:0] sol, input logic valid,
                                              input logic [23:0] data);
    int px, py, idx;
    if (h < HB || v < VB) return 24'h0;
    px = h - HB;
    py = v - VB;
    case (md)
      2'd0: return ((px % GRID_STEP == 0) || (py % GRID_STEP == 0)) ? 24'hFFFFFF : 24'h0;
      2'd1: begin
        idx = px / (HDISP / 8);
        if (idx > 7) idx = 7;
        return bar_tab[idx];
      end
      2'd2: return sol;
      default: return valid ? data : 24'hFF00FF;
    endcase
  endfunction

  always @(posedge pixel_clk) begin
    int h, v;
    logic act;
    if (pixel_rst) begin
      model_on = 1'b1;
      mt = 0; m_mode = 2'd0; m_solid = 24'h0; m_uflow = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = 24'h0;
    end else if (model_on) begin
      h = mt % HT;
      v = mt / HT;
      act = (h >= HB) && (v >= VB);
      e_hs = !(h >= HFP && h < HFP + HPULSE);
      e_vs = !(v >= VFP && v < VFP + VPULSE);
      e_blank = act;
      e_rgb = modelPixel(h, v, m_mode, m_solid, pix_valid, pix_data);
      if (act && m_mode == 2'd3 && !pix_valid) m_uflow = 1'b1;
      else if (uflow_clr)                      m_uflow = 1'b0;
      if (mt == 0) begin
        m_mode  = mode;
        m_solid = solid_rgb;
      end
      mt = (mt + 1) % FRAME;
    end
  end

  always @(negedge pixel_clk) begin
    int h, v;
    logic act, rdy;
    if (model_on) begin
      h = mt % HT;
      v = mt / HT;
      act = (h >= HB) && (v >= VB);
      rdy = !pixel_rst && act && (m_mode == 2'd3);
      checkOutput("HS", vif.HS, e_hs);
      checkOutput("VS", vif.VS, e_vs);
      checkOutput("BLANK", vif.BLANK, e_blank);
      checkOutput("RGB", vif.RGB, e_rgb);
      checkOutput("uflow", uflow, m_uflow);
      checkOutput("pix_rdy", pix_rdy, rdy);
      checkOutput("pix_sof", pix_sof, rdy && (h == HB) && (v == VB));
    end
  end

  bit xfer, sof_seen, auto_inc;

  task automatic applyStimulus(input logic rst, input logic [1:0] md, input logic [23:0] sol,
                               input logic valid, input logic clr);
    pixel_rst = rst; mode = md; solid_rgb = sol; pix_valid = valid; uflow_clr = clr;
  endtask

  task automatic tick();
    @(negedge pixel_clk);
    xfer     = pix_rdy && pix_valid;
    sof_seen = pix_sof;
    @(posedge pixel_clk);
    #2;
    if (auto_inc && xfer) pix_data = pix_data + 24'd1;
  endtask

  task automatic waitCount(input int target);
    int n = 0;
    while (mt != target && n < 3 * FRAME) begin
      tick();
      n++;
    end
    checkOutput("wait_position", mt, target);
  endtask

  initial begin
    int hs_low, vs_low, blank_cnt, white_cnt, blank_rgb, xfers, sofs;
    logic [23:0] seq;
    bit first;
    pix_data = 24'h0;
    auto_inc = 1'b0;
    applyStimulus(1'b1, 2'd0, 24'h0, 1'b0, 1'b0);
    repeat (3) tick();
    applyStimulus(1'b0, 2'd0, 24'h0, 1'b0, 1'b0);

    // One full frame of grid timing, outputs lag the counters by one cycle.
    hs_low = 0; vs_low = 0; blank_cnt = 0; white_cnt = 0; blank_rgb = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (vif.HS == 1'b0) hs_low++;
      if (vif.VS == 1'b0) vs_low++;
      if (vif.BLANK) blank_cnt++;
      if (vif.BLANK && vif.RGB == 24'hFFFFFF) white_cnt++;
      if (!vif.BLANK && vif.RGB != 24'h0) blank_rgb++;
    end
    checkOutput("hs_low_clocks_per_frame", hs_low, 14);
    checkOutput("vs_low_clocks_per_frame", vs_low, 14);
    checkOutput("blank_high_per_frame", blank_cnt, 32);
    checkOutput("grid_white_pixels", white_cnt, 14);
    checkOutput("rgb_nonzero_in_blanking", blank_rgb, 0);

    // Stream mode with an always-valid incrementing source.
    applyStimulus(1'b0, 2'd3, 24'h0, 1'b1, 1'b0);
    auto_inc = 1'b1;
    xfers = 0; sofs = 0; seq = 24'h0; first = 1'b1;
    for (int i = 0; i <= FRAME; i++) begin
      tick();
      if (xfer) begin
        xfers++;
        if (first) checkOutput("first_transfer_sof", sof_seen, 1'b1);
        first = 1'b0;
      end
      if (sof_seen) sofs++;
      if (vif.BLANK) begin
        checkOutput("stream_rgb_sequence", vif.RGB, seq);
        seq = seq + 24'd1;
      end
    end
    checkOutput("transfers_per_frame", xfers, 32);
    checkOutput("sof_per_frame", sofs, 1);
    checkOutput("uflow_after_clean_frame", uflow, 1'b0);

    // Underflow, set-beats-clear, then clear alone.
    waitCount(51);
    pix_valid = 1'b0;
    tick();
    checkOutput("uflow_pixel_colour", vif.RGB, 24'hFF00FF);
    checkOutput("uflow_set", uflow, 1'b1);
    pix_valid = 1'b1;
    tick();
    checkOutput("uflow_holds", uflow, 1'b1);
    pix_valid = 1'b0; uflow_clr = 1'b1;
    tick();
    checkOutput("uflow_set_beats_clear", uflow, 1'b1);
    pix_valid = 1'b1;
    tick();
    checkOutput("uflow_cleared", uflow, 1'b0);
    uflow_clr = 1'b0;

    // Grid for a frame, switch to solid mid-frame.
    mode = 2'd0;
    waitCount(0);
    waitCount(60);
    mode = 2'd2; solid_rgb = 24'h123456;
    waitCount(63);
    checkOutput("grid_continues_mid_frame", vif.RGB, 24'hFFFFFF);
    waitCount(0);
    waitCount(49);
    checkOutput("solid_next_frame", vif.RGB, 24'h123456);

    // Mid-frame reset at h=9, v=5, releasing into bars mode.
    waitCount(5 * HT + 9);
    applyStimulus(1'b1, 2'd1, 24'h123456, 1'b1, 1'b0);
    tick();
    checkOutput("rst_hs", vif.HS, 1'b1);
    checkOutput("rst_vs", vif.VS, 1'b1);
    checkOutput("rst_blank", vif.BLANK, 1'b0);
    checkOutput("rst_rgb", vif.RGB, 24'h0);
    checkOutput("rst_pix_rdy", pix_rdy, 1'b0);
    checkOutput("rst_mode_q", dut.mode_q, 2'd0);
    pixel_rst = 1'b0;
    tick();
    tick();
    checkOutput("hs_idle_before_pulse", vif.HS, 1'b1);
    tick();
    checkOutput("hs_pulse_after_release", vif.HS, 1'b0);
    waitCount(51);
    checkOutput("bars_cyan_at_x2", vif.RGB, 24'h00FFFF);
    repeat (FRAME) tick();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
